// File: rtl/ultrasound_sweep_ranger.sv
// rtl/ultrasound_sweep_ranger.sv - six-angle ultrasound sweep sequencer producing packed r_theta reports
module ultrasound_sweep_ranger #(
    parameter int SETTLE_CYCLES = 13_500_000,
    parameter int TRIG_CYCLES   = 270,
    parameter int UNIT_CYCLES   = 4000,
    parameter int ECHO_TIMEOUT  = 1_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        echo,
    output logic        trigger,
    output logic [3:0]  angle_index,
    output logic [11:0] r_theta,
    output logic        r_theta_valid,
    output logic        sweep_done,
    output logic        busy
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (TRIG_CYCLES   > 1) ? $clog2(TRIG_CYCLES)   : 1;
    localparam int UW = (UNIT_CYCLES   > 1) ? $clog2(UNIT_CYCLES)   : 1;
    localparam int WW = (ECHO_TIMEOUT  > 1) ? $clog2(ECHO_TIMEOUT)  : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TRIG_LAST   = TW'(TRIG_CYCLES - 1);
    localparam logic [UW-1:0] UNIT_LAST   = UW'(UNIT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST   = WW'(ECHO_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        TRIGGER,
        WAIT_ECHO,
        MEASURE,
        REPORT
    } state_t;

    state_t state, state_nx;

    logic          echo_m, echo_s;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] trig_cnt;
    logic [WW-1:0] wait_cnt;
    logic [UW-1:0] sub_cnt;
    logic [7:0]    r;

    logic settle_end, trig_end, wait_end, unit_end;

    assign settle_end = (settle_cnt == SETTLE_LAST);
    assign trig_end   = (trig_cnt == TRIG_LAST);
    assign wait_end   = (wait_cnt == WAIT_LAST);
    assign unit_end   = (sub_cnt == UNIT_LAST);

    assign trigger = (state == TRIGGER);
    assign busy    = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (enable) state_nx = SETTLE;
            SETTLE:    if (settle_end && !echo_s) state_nx = TRIGGER;
            TRIGGER:   if (trig_end) state_nx = WAIT_ECHO;
            WAIT_ECHO: begin
                if (echo_s)        state_nx = MEASURE;
                else if (wait_end) state_nx = REPORT;
            end
            MEASURE: begin
                if (!echo_s)                          state_nx = REPORT;
                else if (unit_end && r == 8'd254)     state_nx = REPORT;
            end
            REPORT:    state_nx = enable ? SETTLE : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt    <= '0;
            trig_cnt      <= '0;
            wait_cnt      <= '0;
            sub_cnt       <= '0;
            r             <= 8'd0;
            angle_index   <= 4'h1;
            r_theta       <= 12'h100;
            r_theta_valid <= 1'b0;
            sweep_done    <= 1'b0;
        end else begin
            r_theta_valid <= 1'b0;
            sweep_done    <= 1'b0;
            case (state)
                IDLE: settle_cnt <= '0;
                SETTLE: begin
                    if (!settle_end) settle_cnt <= settle_cnt + SW'(1);
                    trig_cnt <= '0;
                end
                TRIGGER: begin
                    if (!trig_end) trig_cnt <= trig_cnt + TW'(1);
                    wait_cnt <= '0;
                end
                WAIT_ECHO: begin
                    // The rising-edge cycle is itself a high cycle, so it is pre-counted.
                    if (echo_s) begin
                        sub_cnt <= UW'(1);
                        r       <= 8'd0;
                    end else if (wait_end) begin
                        r <= 8'hFF;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                MEASURE: begin
                    if (echo_s) begin
                        if (unit_end) begin
                            sub_cnt <= '0;
                            if (r != 8'hFF) r <= r + 8'd1;
                        end else begin
                            sub_cnt <= sub_cnt + UW'(1);
                        end
                    end
                end
                REPORT: begin
                    r_theta       <= {angle_index, r};
                    r_theta_valid <= 1'b1;
                    sweep_done    <= (angle_index == 4'd6);
                    angle_index   <= (angle_index == 4'd6) ? 4'h1 : angle_index + 4'd1;
                    settle_cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasound_sweep_ranger.sv
// tb/tb_ultrasound_sweep_ranger.sv - self-checking bench for ultrasound_sweep_ranger
module tb_ultrasound_sweep_ranger;

    localparam int SETTLE  = 20;
    localparam int TRIG    = 4;
    localparam int UNIT    = 10;
    localparam int TIMEOUT = 50;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        echo;
    logic        trigger;
    logic [3:0]  angle_index;
    logic [11:0] r_theta;
    logic        r_theta_valid;
    logic        sweep_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int angle_m = 1;

    typedef struct {
        int          delay;
        int          len;
        logic [11:0] word;
        logic        done;
    } vec_t;

    vec_t tbl[6];

    always #5 clock = ~clock;

    ultrasound_sweep_ranger #(
        .SETTLE_CYCLES(SETTLE),
        .TRIG_CYCLES  (TRIG),
        .UNIT_CYCLES  (UNIT),
        .ECHO_TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .echo         (echo),
        .trigger      (trigger),
        .angle_index  (angle_index),
        .r_theta      (r_theta),
        .r_theta_valid(r_theta_valid),
        .sweep_done   (sweep_done),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_r(input int len);
        if (len == 0) return 255;
        if (len / UNIT > 255) return 255;
        return len / UNIT;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_trigger"}, 32'(trigger), 32'd0);
        chk({tag, "_angle"}, 32'(angle_index), 32'd1);
        chk({tag, "_r_theta"}, 32'(r_theta), 32'h100);
        chk({tag, "_valid"}, 32'(r_theta_valid), 32'd0);
        chk({tag, "_done"}, 32'(sweep_done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        angle_m = 1;
    endtask

    task automatic wait_trigger(output int tl);
        int n = 0;
        tl = 0;
        while (!trigger && n < 4000) begin
            @(negedge clock);
            n++;
        end
        chk("trigger_seen", 32'(trigger), 32'd1);
        while (trigger && tl < 100) begin
            @(negedge clock);
            tl++;
        end
    endtask

    // Cycle index c counts negedges after trigger is first seen low.
    task automatic run_angle(input int delay, input int len, input int drop_at,
                             output logic [11:0] word, output logic done,
                             output int lat, output int tl);
        bit got = 1'b0;
        bit dbl = 1'b0;
        bit trig_in = 1'b0;
        int vc = -1;
        int limit;
        word = '0;
        done = 1'b0;
        wait_trigger(tl);
        limit = delay + len + TIMEOUT + 30;
        echo = 1'b0;
        for (int c = 1; c < limit; c++) begin
            @(negedge clock);
            if (r_theta_valid) begin
                if (got) dbl = 1'b1;
                else begin
                    got  = 1'b1;
                    vc   = c;
                    word = r_theta;
                    done = sweep_done;
                end
            end
            if (trigger) trig_in = 1'b1;
            if (c == drop_at) enable = 1'b0;
            echo = (c >= delay) && (c < delay + len);
            if (got && c > vc && c >= delay + len) break;
        end
        echo = 1'b0;
        lat = vc;
        chk("valid_seen", 32'(got), 32'd1);
        chk("valid_single", 32'(dbl), 32'd0);
        chk("trigger_withheld", 32'(trig_in), 32'd0);
    endtask

    task automatic do_angle(input string name, input int delay, input int len,
                            input int drop_at, input logic [11:0] exp_word);
        logic [11:0] word;
        logic        done;
        int          lat, tl;
        run_angle(delay, len, drop_at, word, done, lat, tl);
        chk({name, "_word"}, 32'(word), 32'(exp_word));
        chk({name, "_done"}, 32'(done), 32'(angle_m == 6));
        chk({name, "_trig_len"}, 32'(tl), 32'(TRIG));
        if (len == 0)
            chk({name, "_lat_timeout"}, 32'(lat), 32'(TIMEOUT + 1));
        else if (len / UNIT < 255)
            chk({name, "_lat_fall"}, 32'(lat), 32'(delay + len + 4));
        angle_m = (angle_m == 6) ? 1 : angle_m + 1;
    endtask

    initial begin
        logic [11:0] w;
        int d, l, tl;
        bit vflag;

        tbl[0] = '{delay: 1, len: 30, word: 12'h103, done: 1'b0};
        tbl[1] = '{delay: 2, len: 30, word: 12'h203, done: 1'b0};
        tbl[2] = '{delay: 3, len: 30, word: 12'h303, done: 1'b0};
        tbl[3] = '{delay: 4, len: 30, word: 12'h403, done: 1'b0};
        tbl[4] = '{delay: 5, len: 30, word: 12'h503, done: 1'b0};
        tbl[5] = '{delay: 6, len: 30, word: 12'h603, done: 1'b1};

        reset_n = 1'b0;
        enable  = 1'b0;
        echo    = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_without_enable", 32'(busy), 32'd0);
        enable = 1'b1;

        do_angle("basic57", 3, 57, -1, 12'h105);
        chk("basic57_angle_adv", 32'(angle_index), 32'd2);

        pulse_reset();
        do_angle("timeout", 5, 0, -1, 12'h1FF);
        chk("timeout_angle_adv", 32'(angle_index), 32'd2);

        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("sweep%0d_table_done", i), 32'(tbl[i].done), 32'(angle_m == 6));
            do_angle($sformatf("sweep%0d", i), tbl[i].delay, tbl[i].len, -1, tbl[i].word);
        end
        chk("sweep_wrap_angle", 32'(angle_index), 32'd1);

        do_angle("saturate", 2, 3000, -1, 12'h1FF);
        do_angle("after_sat", 2, 45, -1, 12'h204);

        for (int i = 0; i < 12; i++) begin
            d = int'($urandom_range(20, 1));
            l = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(600, 1));
            w = {4'(angle_m), 8'(model_r(l))};
            do_angle($sformatf("rand%0d", i), d, l, -1, w);
            chk($sformatf("rand%0d_angle", i), 32'(angle_index), 32'(angle_m));
        end

        pulse_reset();
        do_angle("pre1", 2, 12, -1, 12'h101);
        do_angle("pre2", 2, 99, -1, 12'h209);
        do_angle("drop", 3, 40, 3 + 15, 12'h304);
        repeat (3) @(negedge clock);
        chk("drop_idle", 32'(busy), 32'd0);
        chk("drop_angle", 32'(angle_index), 32'd4);
        chk("drop_no_trigger", 32'(trigger), 32'd0);
        enable = 1'b1;
        do_angle("resume", 2, 25, -1, 12'h402);

        wait_trigger(tl);
        repeat (3) @(negedge clock);
        echo = 1'b1;
        repeat (15) @(negedge clock);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_values("abort");
        echo  = 1'b0;
        vflag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (r_theta_valid) vflag = 1'b1;
        end
        chk("abort_no_valid", 32'(vflag), 32'd0);
        reset_n = 1'b1;
        angle_m = 1;
        do_angle("post_abort", 4, 77, -1, 12'h107);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
